reg_bank: RTL
=============

Name: reg_bank

Overview:
Parametrised bank of DEPTH registers, each DW bits wide. It is the multi-entry successor to the single load-enabled register. Supports addressed parallel write, serial shift-in (weight/input streaming into neuron datapaths), synchronous clear, a registered read port and a flattened all-entries output. It tracks fill level so a controller knows when a full vector has been streamed in.

Parameters:
DW, 16, data width of each entry
DEPTH, 8, number of entries (>= 2)
AW, 3, address width; must satisfy 2^AW >= DEPTH

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
clr  input  1  synchronous clear of entries and fill count
wr_en  input  1  addressed write enable
wr_addr  input  AW  write address
wr_data  input  DW  write data
shift_en  input  1  shift enable: entry[0] <= shift_in, entry[i] <= entry[i-1]
shift_in  input  DW  serial data in
rd_addr  input  AW  read address
rd_data  output  DW  registered read data
shift_out  output  DW  current entry[DEPTH-1] (direct register output)
shift_out_vld  output  1  pulses 1 cycle after a shift performed while full (entry evicted)
all_out  output  DEPTH*DW  all entries flattened; entry i at bits [i*DW +: DW]
count  output  AW+1  fill level, 0..DEPTH
full  output  1  count == DEPTH

Behaviour:
- Reset (rst=1 at clk edge): all entries, rd_data, count, shift_out_vld <= 0. rst has highest priority over every other input.
- Update priority per cycle: rst > clr > shift_en > wr_en.
  - A lower-priority request in the same cycle is dropped, not deferred.
- clr: all entries and count <= 0; shift_out_vld <= 0. rd_data still updates from the pre-clear array (read-before-write).
- shift_en (no rst/clr):
  - Entries shift one position toward DEPTH-1; entry[0] <= shift_in.
  - count <= count+1, saturating at DEPTH.
  - shift_out_vld <= 1 iff full was 1 before the shift (old entry[DEPTH-1] discarded).
  - Otherwise shift_out_vld <= 0.
- wr_en (no rst/clr/shift_en):
  - entry[wr_addr] <= wr_data; count unchanged.
  - wr_addr >= DEPTH: write ignored, no entry changes.
- No enables active: entries and count hold; shift_out_vld <= 0.
- Read port:
  - rd_data <= entry[rd_addr] every cycle, 1-cycle latency.
  - Read-before-write: when the addressed entry is written or shifted in the same cycle, rd_data returns the OLD value. New value visible on the following read.
  - rd_addr >= DEPTH: rd_data <= 0.
- all_out, shift_out, full: purely combinational from registered state, zero latency after the edge.
- count width AW+1 so DEPTH is representable; never exceeds DEPTH and never wraps.
- No arithmetic on data; values pass bit-exact.

Test Plan:
- Reset: drive random state, assert rst 1 cycle with shift_en=wr_en=1 -> next cycle all_out=0, count=0, full=0, rd_data=0, shift_out_vld=0.
- Shift fill (DW=16, DEPTH=8): shift in 1..8 on consecutive cycles -> count 1..8, full=1 after 8th, all_out entry0=8 ... entry7=1, shift_out=1. Shift 9 -> shift_out_vld=1 next cycle, shift_out=2, count stays 8.
- Addressed write/read: write 16'hABCD to addr 5 while rd_addr=5 -> rd_data is old value that cycle, 16'hABCD on next read; write to addr 9 (AW=4, DEPTH=8) -> no entry changes; rd_addr=9 -> rd_data=0.
- Priority: same cycle shift_en=1, wr_en=1 (addr 0, 16'h1111), shift_in=16'h2222 -> entry0=16'h2222, write dropped. clr with shift_en -> all entries 0, count=0.
- Clear mid-fill: shift 3 values, clr -> count=0, all_out=0. Then shift 8 more -> full=1 exactly on 8th.
- Hold: no enables for 10 cycles -> all_out, count unchanged; shift_out_vld=0 throughout.

Source files
------------

// File: rtl/reg_bank.sv
// Register bank with addressed write, serial shift-in, sync clear, registered read
// and a fill counter so a controller knows when a full vector has streamed in.

module reg_bank_entry #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          shift_en,
  input  logic          wr_sel,
  input  logic [DW-1:0] shift_d,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] q
);
  // Shift beats the addressed write; the losing request is simply dropped.
  always_ff @(posedge clk) begin
    if (rst || clr)    q <= '0;
    else if (shift_en) q <= shift_d;
    else if (wr_sel)   q <= wr_data;
  end
endmodule

module reg_bank #(
  parameter int DW    = 16,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [DW-1:0]       wr_data,
  input  logic                shift_en,
  input  logic [DW-1:0]       shift_in,
  input  logic [AW-1:0]       rd_addr,
  output logic [DW-1:0]       rd_data,
  output logic [DW-1:0]       shift_out,
  output logic                shift_out_vld,
  output logic [DEPTH*DW-1:0] all_out,
  output logic [AW:0]         count,
  output logic                full
);
  localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);

  logic [DEPTH-1:0][DW-1:0] ent;
  logic [DEPTH-1:0][DW-1:0] shift_d;
  logic [DEPTH-1:0]         wr_sel;
  logic [DW-1:0]            rd_mux;

  // Out-of-range write addresses match no entry, so they fall away naturally.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    if (i == 0) begin : g_head
      assign shift_d[i] = shift_in;
    end else begin : g_body
      assign shift_d[i] = ent[i-1];
    end
    assign wr_sel[i] = wr_en && (wr_addr == AW'(i));

    reg_bank_entry #(.DW(DW)) u_ent (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .shift_en (shift_en),
      .wr_sel   (wr_sel[i]),
      .shift_d  (shift_d[i]),
      .wr_data  (wr_data),
      .q        (ent[i])
    );
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < DEPTH; i++)
      if (rd_addr == AW'(i)) rd_mux = ent[i];
  end

  // Read samples the pre-update array, including on a clear.
  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else     rd_data <= rd_mux;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count         <= '0;
      shift_out_vld <= 1'b0;
    end else begin
      shift_out_vld <= shift_en && full;
      if (shift_en && !full) count <= count + (AW+1)'(1);
    end
  end

  assign full      = (count == CNT_MAX);
  assign shift_out = ent[DEPTH-1];
  assign all_out   = ent;
endmodule
